// File: rtl/buffer2axis.sv
// ---------------------------------------------------------------------------
// buffer2axis
//
// Serialises one WIDTH-cell row of cell states per input handshake onto an
// AXI4-Stream master, one DWIDTH-bit colour pixel per cell. Bit 0 of the row
// is sent first. Rows are counted so that TLAST marks the final pixel of each
// HEIGHT-row frame, and frame_done pulses for one cycle after that pixel has
// been accepted.
//
// Ports:
//   clk            single clock, all state on the rising edge
//   rstn           asynchronous active-low reset
//   alive_color    pixel value for a live cell (bit = 1)
//   dead_color     pixel value for a dead cell (bit = 0)
//   in_data        row of cell states, bit 0 is the first pixel sent
//   in_valid       in_data valid
//   in_ready       block can accept a row (registered)
//   M_AXIS_TDATA   pixel data (registered)
//   M_AXIS_TVALID  pixel valid (registered)
//   M_AXIS_TREADY  downstream accepts pixel
//   M_AXIS_TLAST   last pixel of frame (registered)
//   frame_done     one-cycle pulse after the last pixel of a frame is taken
// ---------------------------------------------------------------------------
module buffer2axis #(
    parameter int DWIDTH = 32,
    parameter int WIDTH  = 4,
    parameter int HEIGHT = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DWIDTH-1:0] alive_color,
    input  logic [DWIDTH-1:0] dead_color,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DWIDTH-1:0] M_AXIS_TDATA,
    output logic              M_AXIS_TVALID,
    input  logic              M_AXIS_TREADY,
    output logic              M_AXIS_TLAST,
    output logic              frame_done
);

    // Terminal counts sized to the counters so compares are width-exact;
    // wrap is always done by these compares, never by counter overflow.
    localparam logic [7:0]  COL_LAST = 8'(WIDTH - 1);
    localparam logic [15:0] ROW_LAST = 16'(HEIGHT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        col_q, col_d;
    logic [15:0]       row_q, row_d;
    logic [WIDTH-1:0]  row_buf_q, row_buf_d;
    logic [DWIDTH-1:0] alive_q, alive_d;
    logic [DWIDTH-1:0] dead_q, dead_d;
    logic [DWIDTH-1:0] tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic              in_ready_q, in_ready_d;
    logic              frame_done_q, frame_done_d;

    logic [7:0]        col_next;
    logic [WIDTH-1:0]  row_shifted;

    // Every output comes straight from a register. Reset clears everything,
    // so an in-flight row is discarded and TVALID drops without a clock.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            row_buf_q    <= '0;
            alive_q      <= '0;
            dead_q       <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            in_ready_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            row_buf_q    <= row_buf_d;
            alive_q      <= alive_d;
            dead_q       <= dead_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            in_ready_q   <= in_ready_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state and next-output logic. Holding every register by default is
    // what keeps TDATA/TLAST/TVALID stable while the downstream stalls.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        row_buf_d    = row_buf_q;
        alive_d      = alive_q;
        dead_d       = dead_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        in_ready_d   = in_ready_q;
        frame_done_d = 1'b0;

        col_next     = col_q + 8'd1;
        row_shifted  = row_buf_q >> col_next;

        unique case (state_q)
            IDLE: begin
                tvalid_d   = 1'b0;
                tlast_d    = 1'b0;
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    // Colours are latched with the row so later changes on
                    // the colour inputs only affect the next row.
                    row_buf_d  = in_data;
                    alive_d    = alive_color;
                    dead_d     = dead_color;
                    col_d      = '0;
                    tdata_d    = in_data[0] ? alive_color : dead_color;
                    tlast_d    = (WIDTH == 1) && (row_q == ROW_LAST);
                    tvalid_d   = 1'b1;
                    in_ready_d = 1'b0;
                    state_d    = SEND;
                end
            end

            SEND: begin
                in_ready_d = 1'b0;
                if (M_AXIS_TREADY) begin
                    if (col_q == COL_LAST) begin
                        state_d    = IDLE;
                        tvalid_d   = 1'b0;
                        tlast_d    = 1'b0;
                        in_ready_d = 1'b1;
                        if (row_q == ROW_LAST) begin
                            row_d        = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            row_d = row_q + 16'd1;
                        end
                    end else begin
                        col_d   = col_next;
                        tdata_d = row_shifted[0] ? alive_q : dead_q;
                        tlast_d = (col_next == COL_LAST) && (row_q == ROW_LAST);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready      = in_ready_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_buffer2axis.sv
// ---------------------------------------------------------------------------
// tb_buffer2axis
//
// Directed bench for buffer2axis with WIDTH=4, HEIGHT=2. Each accepted row
// pushes its expected beats (pixel, TLAST, end-of-row) onto a scoreboard;
// beats are compared against the queue head whenever TVALID is high and
// popped when the handshake completes.
// ---------------------------------------------------------------------------
module tb_buffer2axis;

    localparam int DWIDTH = 32;
    localparam int WIDTH  = 4;
    localparam int HEIGHT = 2;

    typedef struct {
        logic [DWIDTH-1:0] data;
        logic              last;
        logic              row_end;
    } beat_t;

    logic              clk;
    logic              rstn;
    logic [DWIDTH-1:0] alive_color;
    logic [DWIDTH-1:0] dead_color;
    logic [WIDTH-1:0]  in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DWIDTH-1:0] M_AXIS_TDATA;
    logic              M_AXIS_TVALID;
    logic              M_AXIS_TREADY;
    logic              M_AXIS_TLAST;
    logic              frame_done;

    beat_t sb[$];
    int    compared;
    int    mismatched;
    int    beats_done;
    int    model_row;
    int    cyc;
    logic  exp_frame_done;
    logic  exp_ready_next;
    bit    stall_pattern [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    buffer2axis #(
        .DWIDTH(DWIDTH),
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .alive_color  (alive_color),
        .dead_color   (dead_color),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .M_AXIS_TDATA (M_AXIS_TDATA),
        .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TREADY(M_AXIS_TREADY),
        .M_AXIS_TLAST (M_AXIS_TLAST),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left on a falling edge. Outputs are
    // checked here; a beat counts as accepted when TVALID and TREADY are
    // both high ahead of the next rising edge.
    task automatic step(input logic rdy);
        logic fd_next;
        beat_t b;
        fd_next = 1'b0;
        M_AXIS_TREADY = rdy;
        checkOutput("frame_done", 32'(frame_done), 32'(exp_frame_done));
        if (exp_ready_next) begin
            checkOutput("in_ready_after_row", 32'(in_ready), 32'd1);
            checkOutput("tvalid_after_row", 32'(M_AXIS_TVALID), 32'd0);
        end
        exp_ready_next = 1'b0;
        if (M_AXIS_TVALID) begin
            compared++;
            assert (sb.size() > 0)
            else begin
                mismatched++;
                $error("[TB] FAIL unexpected_beat: observed tdata %h expected no beat", M_AXIS_TDATA);
            end
            if (sb.size() > 0) begin
                b = sb[0];
                checkOutput("tdata", M_AXIS_TDATA, b.data);
                checkOutput("tlast", 32'(M_AXIS_TLAST), 32'(b.last));
                if (rdy) begin
                    void'(sb.pop_front());
                    beats_done++;
                    fd_next        = b.last;
                    exp_ready_next = b.row_end;
                end
            end
        end else begin
            checkOutput("tlast_without_tvalid", 32'(M_AXIS_TLAST), 32'd0);
        end
        cyc++;
        @(negedge clk);
        exp_frame_done = fd_next;
    endtask

    // Offer a row and hold it until in_ready accepts it, then push its
    // expected beats using the colours present at the accepting edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] row);
        bit    accepted;
        beat_t b;
        accepted = 1'b0;
        in_data  = row;
        in_valid = 1'b1;
        for (int t = 0; t < 30 && !accepted; t++) begin
            if (in_ready === 1'b1) begin
                for (int i = 0; i < WIDTH; i++) begin
                    b.data    = row[i] ? alive_color : dead_color;
                    b.last    = (i == WIDTH - 1) && (model_row == HEIGHT - 1);
                    b.row_end = (i == WIDTH - 1);
                    sb.push_back(b);
                end
                model_row = (model_row == HEIGHT - 1) ? 0 : model_row + 1;
                accepted  = 1'b1;
            end
            step(1'b1);
        end
        in_valid = 1'b0;
        if (!accepted) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL row_accept_timeout: observed in_ready %b expected 1", in_ready);
        end else begin
            checkOutput("tvalid_latency", 32'(M_AXIS_TVALID), 32'd1);
        end
    endtask

    // Run until n more beats are accepted; mode 1 applies the stall pattern.
    task automatic drainBeats(input int n, input int mode);
        int target;
        target = beats_done + n;
        for (int t = 0; t < 100 && beats_done < target; t++) begin
            step(mode == 1 ? logic'(stall_pattern[cyc % 6]) : 1'b1);
        end
        if (beats_done < target) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL drain_timeout: observed %0d beats expected %0d", beats_done, target);
        end
    endtask

    initial begin
        compared       = 0;
        mismatched     = 0;
        beats_done     = 0;
        model_row      = 0;
        cyc            = 0;
        exp_frame_done = 1'b0;
        exp_ready_next = 1'b0;
        rstn           = 1'b0;
        in_valid       = 1'b0;
        in_data        = '0;
        M_AXIS_TREADY  = 1'b0;
        alive_color    = 32'h00FF_FFFF;
        dead_color     = 32'h0000_0000;

        // Reset: every output low while held.
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
        checkOutput("rst_tdata", M_AXIS_TDATA, 32'd0);
        checkOutput("rst_tlast", 32'(M_AXIS_TLAST), 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("in_ready_after_release", 32'(in_ready), 32'd1);
        checkOutput("tvalid_after_release", 32'(M_AXIS_TVALID), 32'd0);

        // Row 0 then row 1 (frame end), then a third row back at row 0.
        $display("[TB] rows 0101 / 1000 / 0011 with TREADY high");
        applyStimulus(4'b0101);
        drainBeats(4, 0);
        applyStimulus(4'b1000);
        drainBeats(4, 0);
        applyStimulus(4'b0011);
        drainBeats(4, 0);

        // Backpressure with a colour change after the first beat.
        $display("[TB] row 1111 under backpressure");
        applyStimulus(4'b1111);
        drainBeats(1, 1);
        alive_color = 32'h1234_5678;
        drainBeats(3, 1);
        alive_color = 32'h00FF_FFFF;

        // Mid-row reset on row 1.
        $display("[TB] reset after beat 2 of row 1");
        applyStimulus(4'b0011);
        drainBeats(4, 0);
        applyStimulus(4'b1010);
        drainBeats(2, 0);
        #2 rstn = 1'b0;
        #1;
        checkOutput("async_rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
        checkOutput("async_rst_tlast", 32'(M_AXIS_TLAST), 32'd0);
        checkOutput("async_rst_tdata", M_AXIS_TDATA, 32'd0);
        sb.delete();
        model_row      = 0;
        exp_frame_done = 1'b0;
        exp_ready_next = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("in_ready_after_rst2", 32'(in_ready), 32'd1);
        applyStimulus(4'b1001);
        drainBeats(4, 0);
        step(1'b1);
        step(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/buffer2axis.md
Name: buffer2axis

Overview:
- Transmit-side counterpart of the conware AXIS ingest path: takes one WIDTH-cell row of computed cell states per handshake and serialises it onto an AXI4-Stream master as one DWIDTH-bit colour pixel per cell.
- Sits between the conware computation core and the output VDMA/stream FIFO.
- Counts rows and asserts TLAST on the final pixel of each HEIGHT-row frame.

Parameters:
- DWIDTH, 32, pixel/colour width in bits.
- WIDTH, 4, cells per row; 1..256.
- HEIGHT, 4, rows per frame; 1..65536.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rstn  input  1  asynchronous active-low reset; deassertion synchronous to clk externally.
- alive_color  input  DWIDTH  pixel value emitted for a live cell (bit=1).
- dead_color  input  DWIDTH  pixel value emitted for a dead cell (bit=0).
- in_data  input  WIDTH  row of cell states; bit 0 is the first pixel sent.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a row.
- M_AXIS_TDATA  output  DWIDTH  pixel data.
- M_AXIS_TVALID  output  1  pixel valid.
- M_AXIS_TREADY  input  1  downstream accepts pixel.
- M_AXIS_TLAST  output  1  last pixel of frame.
- frame_done  output  1  one-cycle pulse after the final pixel of a frame is accepted.

Behaviour:
- Reset (rstn=0, asynchronous): state=Idle, col=0, row=0, row_buf=0, colour latches=0. All outputs driven from registers: in_ready=0, M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TLAST=0, frame_done=0.
- Reset asserted mid-row or mid-frame: the partial row is discarded and TVALID drops immediately. The next frame starts at row 0.
- States:
  - Idle: in_ready=1 (registered; reads 1 from the first clock edge after reset release), TVALID=0.
  - Send: in_ready=0, TVALID=1.
- Idle->Send on in_valid&&in_ready:
  - Capture in_data into row_buf.
  - Latch alive_color/dead_color.
  - col=0.
  - Register TDATA = row_buf[0] ? alive : dead.
  - TLAST = (WIDTH==1 && row==HEIGHT-1).
  - TVALID rises the cycle after the accept (latency 1 clock).
- In Send:
  - TDATA, TLAST and TVALID are held stable while TREADY=0 (AXIS rule). There is no timeout and no drop.
  - Changes on alive_color/dead_color after capture have no effect until the next row.
  - On TVALID&&TREADY with col<WIDTH-1: col++, TDATA = colour of row_buf[col+1]. TLAST = (col+1==WIDTH-1)&&(row==HEIGHT-1).
  - On TVALID&&TREADY with col==WIDTH-1: go to Idle, TVALID=0, TLAST=0.
    - If row==HEIGHT-1: row=0 and frame_done=1 for exactly the next cycle.
    - Otherwise row++.
- Throughput: WIDTH beats per row plus one Idle cycle (in_ready returns one cycle after the last beat). in_valid arriving while in_ready=0 is held off; the source must keep in_data stable until accepted.
- in_valid in the same cycle as the last beat accept is not taken; it is accepted in the following Idle cycle.
- TLAST only ever coincides with TVALID=1.
- Counter widths: col 8 bits, row 16 bits. Wrap is handled explicitly by the compare against WIDTH-1/HEIGHT-1, never by natural overflow.
- Pixel order per row: bit 0 first, ascending. This matches the ingest block's bit placement, so a loopback reproduces in_data.

Test Plan:
1. Setup for all tests: WIDTH=4, HEIGHT=2, alive=0x00FFFFFF, dead=0x00000000.
2. Reset then release -> outputs 0 during reset; in_ready=1 on the first cycle after release; TVALID=0.
3. Send row 4'b0101 with TREADY held 1 -> TVALID rises 1 cycle after accept. TDATA sequence FFFFFF,000000,FFFFFF,000000. TLAST=0 throughout. in_ready returns 1 the cycle after beat 4.
4. Second row 4'b1000 (row 1) -> TDATA 0,0,0,FFFFFF. TLAST=1 only on beat 4. frame_done pulses one cycle later. A third row restarts at row 0 with TLAST=0.
5. Backpressure: TREADY toggled 1,0,0,1,0,1... during row 4'b1111, with alive_color changed to 0x12345678 mid-row -> TDATA/TLAST stable while stalled. All 4 beats equal 0x00FFFFFF. No beat lost or duplicated.
6. Assert rstn low after beat 2 of row 1 -> TVALID/TLAST/TDATA go to 0 without a clock. The next accepted row emits with TLAST=0 (row counter reset to 0).
